// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the non-pipelined CPU. Accepts one read or write
// request at a time from the control unit, holds it for a fixed latency, then
// returns read data (o_rvalid pulse) or write completion (o_wdone pulse).
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset_n   asynchronous active-low reset
//   i_read    read request, held by the initiator until accepted
//   i_write   write request, held by the initiator until accepted
//   i_addr    request address
//   i_wdata   write data
//   o_ready   idle; a request present at the next edge is accepted
//   o_rdata   read data, valid while o_rvalid, held until the next read
//   o_rvalid  one-cycle read-response pulse
//   o_wdone   one-cycle write-complete pulse
//   o_err     one-cycle pulse after an illegal request (read and write both high)
//   o_busy    inverse of o_ready
//
// State table:
//   IDLE | waiting for a request, o_ready high
//   WAIT | latency countdown on the latched request
//   RESP | response pulse cycle, back to IDLE on the next edge
module mem_responder #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_wdone,
  output logic              o_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter starts at LAT-1 so the response lands exactly LAT edges after accept.
  localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_LAT - 1);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                op_wr_q;
  logic                ready_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic                rvalid_q;
  logic                wdone_q;
  logic                err_q;
  logic                commit_d;

  logic [DWIDTH-1:0]   mem_q [0:(1<<AWIDTH)-1];

  // Edge on which the latched access takes effect (WAIT -> RESP).
  assign commit_d = (state_q == WAIT) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      op_wr_q  <= 1'b0;
      ready_q  <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_read ^ i_write) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            op_wr_q <= i_write;
            cnt_q   <= i_write ? WR_LOAD : RD_LOAD;
            ready_q <= 1'b0;
            state_q <= WAIT;
          end else if (i_read && i_write) begin
            err_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= RESP;
            if (op_wr_q) begin
              wdone_q <= 1'b1;
            end else begin
              rvalid_q <= 1'b1;
              rdata_q  <= mem_q[addr_q];
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Array is not reset. A reset during WAIT forces state_q to IDLE, so an
  // uncommitted write never reaches this block.
  always_ff @(posedge clk) begin
    if (commit_d && op_wr_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign o_ready  = ready_q;
  assign o_busy   = ~ready_q;
  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_wdone  = wdone_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Five instances with different latencies share the
// address/data inputs; each has its own strobes so only one is exercised at a
// time. A per-instance word array plus last-read register is the reference.
module tb_mem_responder;
  localparam int N = 5;

  function automatic int rl_of(input int g);
    case (g)
      2:       return 1;
      3:       return 4;
      4:       return 15;
      default: return 2;
    endcase
  endfunction

  function automatic int wl_of(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  rd_v = '0;
  logic [N-1:0]  wr_v = '0;
  logic [11:0]   addr = '0;
  logic [15:0]   wdata = '0;
  logic [N-1:0]  ready, rvalid, wdone, err, busy;
  logic [15:0]   rdata [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .DWIDTH(16), .AWIDTH(12), .RD_LAT(rl_of(g)), .WR_LAT(wl_of(g))
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .i_read(rd_v[g]), .i_write(wr_v[g]), .i_addr(addr), .i_wdata(wdata),
      .o_ready(ready[g]), .o_rdata(rdata[g]), .o_rvalid(rvalid[g]),
      .o_wdone(wdone[g]), .o_err(err[g]), .o_busy(busy[g])
    );
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] mdl [N][4096];
  logic [15:0] last_rd [N];
  logic [11:0] pool [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int k);
    chk("idle_ready", {ready[k], busy[k]}, 2'b10);
    chk("idle_pulses", {rvalid[k], wdone[k], err[k]}, 3'b000);
    chk("idle_rdata", rdata[k], last_rd[k]);
  endtask

  // One complete access: response must appear exactly LAT edges after the
  // accept edge, for one cycle, and ready must return the edge after.
  task automatic xact(input int k, input bit is_wr, input logic [11:0] a, input logic [15:0] d);
    int lat;
    logic [15:0] exp_rd;
    lat = is_wr ? wl_of(k) : rl_of(k);
    exp_rd = is_wr ? last_rd[k] : mdl[k][a];
    chk("pre_ready", ready[k], 1'b1);
    addr = a; wdata = d;
    rd_v[k] = !is_wr; wr_v[k] = is_wr;
    tick();
    rd_v = '0; wr_v = '0;
    addr = 12'($urandom); wdata = 16'($urandom);
    if (is_wr) mdl[k][a] = d;
    for (int n = 1; n <= lat; n++) begin
      chk("wait_busy", {ready[k], busy[k]}, 2'b01);
      chk("wait_nopulse", {rvalid[k], wdone[k]}, 2'b00);
      chk("wait_rdata", rdata[k], last_rd[k]);
      tick();
    end
    chk("resp_ready", ready[k], 1'b0);
    chk("resp_rvalid", rvalid[k], !is_wr);
    chk("resp_wdone", wdone[k], is_wr);
    chk("resp_rdata", rdata[k], exp_rd);
    last_rd[k] = exp_rd;
    tick();
    check_idle(k);
  endtask

  initial begin
    for (int k = 0; k < N; k++) last_rd[k] = '0;

    // Reset values
    tick();
    for (int k = 0; k < N; k++) check_idle(k);
    #2 reset_n = 1'b1;
    tick();

    // Write then read, default latencies
    xact(0, 1, 12'h005, 16'h1234);
    xact(0, 0, 12'h005, 16'h0000);

    // Boundary addresses
    xact(0, 1, 12'hFFF, 16'hBEEF);
    xact(0, 1, 12'h000, 16'h0001);
    xact(0, 0, 12'hFFF, 16'h0000);
    xact(0, 0, 12'h000, 16'h0000);

    // Held read: accepts every RD_LAT+2 = 4 edges, address change mid-WAIT
    // only affects the next accepted request.
    xact(0, 1, 12'h010, 16'h00AA);
    xact(0, 1, 12'h011, 16'h0BB0);
    addr = 12'h010; rd_v[0] = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) addr = 12'h011;
      if (c == 11) rd_v[0] = 1'b0;
      tick();
      chk("held_rvalid", rvalid[0], (c % 4) == 2);
      chk("held_ready", ready[0], ((c % 4) == 3) || (c == 12));
      if ((c % 4) == 2) last_rd[0] = (c == 2) ? mdl[0][12'h010] : mdl[0][12'h011];
      chk("held_rdata", rdata[0], last_rd[0]);
    end

    // Illegal request
    xact(0, 1, 12'h020, 16'h2020);
    addr = 12'h020; wdata = 16'hDEAD;
    rd_v[0] = 1'b1; wr_v[0] = 1'b1;
    tick();
    rd_v = '0; wr_v = '0;
    chk("ill_err", err[0], 1'b1);
    chk("ill_ready", ready[0], 1'b1);
    chk("ill_pulses", {rvalid[0], wdone[0]}, 2'b00);
    tick();
    check_idle(0);
    xact(0, 0, 12'h020, 16'h0000);

    // Reset mid-write on the WR_LAT=3 instance
    xact(1, 1, 12'h030, 16'h1111);
    xact(1, 0, 12'h030, 16'h0000);
    addr = 12'h030; wdata = 16'h5555; wr_v[1] = 1'b1;
    tick();
    wr_v = '0;
    tick();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) last_rd[k] = '0;
    for (int k = 0; k < N; k++) check_idle(k);
    tick();
    #2 reset_n = 1'b1;
    tick();
    xact(1, 0, 12'h030, 16'h0000);

    // Latency sweep; intervening writes must not disturb o_rdata
    for (int k = 2; k < N; k++) begin
      xact(k, 1, 12'h100, 16'hA5A0 + 16'(k));
      xact(k, 0, 12'h100, 16'h0000);
      xact(k, 1, 12'h101, 16'h3C3C);
      check_idle(k);
      xact(k, 0, 12'h101, 16'h0000);
    end

    // Randomized traffic against the reference arrays
    for (int i = 0; i < 6; i++) pool[i] = 12'($urandom);
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 6; i++) xact(k, 1, pool[i], 16'($urandom));
    for (int i = 0; i < 60; i++) begin
      int k;
      int gap;
      k = int'($urandom_range(0, N - 1));
      gap = int'($urandom_range(0, 2));
      xact(k, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], 16'($urandom));
      for (int j = 0; j < gap; j++) begin
        tick();
        check_idle(k);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
